pps_period_checker: RTL

Downstream monitor for the PPS generator output. It synchronises the generated PPS pulse into the system clock domain and timestamps each pulse against the adjustable clock time, compensating for the synchroniser delay. It also measures period and pulse width in clock cycles, flags missing and early pulses with sticky status bits, and reports lock once the period is stable. It feeds status and timestamp data to the register/CPU side.

---
 rtl/pps_period_checker.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/pps_period_checker.sv
// PPS monitor: synchronises the PPS pulse, timestamps rises against clock time,
// measures period and width, and tracks lock plus sticky missing/early flags.
module pps_period_checker #(
    parameter int unsigned ClockPeriod_Gen     = 20,
    parameter int unsigned PeriodCycles_Gen    = 50000000,
    parameter int unsigned PeriodTolerance_Gen = 100,
    parameter int unsigned LockCount_Gen       = 3,
    parameter string       InputPolarity_Gen   = "true"
) (
    input  logic        SysClk_ClkIn,
    input  logic        SysRstN_RstIn,
    input  logic        Pps_EvtIn,
    input  logic [31:0] ClockTime_Second_DatIn,
    input  logic [31:0] ClockTime_Nanosecond_DatIn,
    input  logic        ClockTime_ValIn,
    input  logic        Enable_EnaIn,
    input  logic        Clear_ValIn,
    output logic [31:0] PpsTime_Second_DatOut,
    output logic [31:0] PpsTime_Nanosecond_DatOut,
    output logic        PpsTime_ValOut,
    output logic [31:0] Period_DatOut,
    output logic [31:0] PulseWidth_DatOut,
    output logic        MissingPps_DatOut,
    output logic        EarlyPps_DatOut,
    output logic        Locked_DatOut
);

    localparam logic active_high = (InputPolarity_Gen == "true");
    localparam logic rest_lvl    = ~active_high;
    localparam logic [31:0] delay_ns = 32'(3 * ClockPeriod_Gen);
    localparam logic [31:0] ns_wrap  = 32'd1000000000 - delay_ns;
    localparam logic [31:0] lo_lim   = 32'(PeriodCycles_Gen - PeriodTolerance_Gen);
    localparam logic [31:0] hi_lim   = 32'(PeriodCycles_Gen + PeriodTolerance_Gen);
    localparam logic [31:0] lock_lim = 32'(LockCount_Gen);
    localparam logic [31:0] max_val  = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        IDLE,
        WAIT_FIRST,
        RUNNING
    } state_t;

    state_t state, state_nx;

    logic sync_a, sync_b, level, level_q;
    logic rise, fall;
    logic [31:0] cnt, wcnt, good;

    logic [31:0] period_meas, good_inc;
    logic [31:0] stamp_sec, stamp_ns;
    logic rise_run, missing_evt, early_evt, good_evt, stamp;

    // Sync flops idle at the inactive level so reset never fakes an edge
    assign level = sync_b ^ rest_lvl;

    always_ff @(posedge SysClk_ClkIn or negedge SysRstN_RstIn) begin
        if (!SysRstN_RstIn) begin
            sync_a  <= rest_lvl;
            sync_b  <= rest_lvl;
            level_q <= 1'b0;
            rise    <= 1'b0;
            fall    <= 1'b0;
        end else begin
            sync_a  <= Pps_EvtIn;
            sync_b  <= sync_a;
            level_q <= level;
            rise    <= level & ~level_q;
            fall    <= ~level & level_q;
        end
    end

    always_ff @(posedge SysClk_ClkIn or negedge SysRstN_RstIn) begin
        if (!SysRstN_RstIn) state <= IDLE;
        else                state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:       if (Enable_EnaIn) state_nx = WAIT_FIRST;
            WAIT_FIRST: if (rise) state_nx = RUNNING;
            RUNNING:    state_nx = RUNNING;
            default:    state_nx = IDLE;
        endcase
        if (!Enable_EnaIn) state_nx = IDLE;

        period_meas = (cnt == max_val) ? cnt : cnt + 32'd1;
        rise_run    = rise && (state == RUNNING);
        missing_evt = (state == RUNNING) && (cnt == hi_lim);
        early_evt   = rise_run && (period_meas < lo_lim);
        good_evt    = rise_run && (period_meas >= lo_lim)
                      && (period_meas <= hi_lim);
        good_inc    = (good >= lock_lim) ? good : good + 32'd1;

        stamp = rise && (state != IDLE) && ClockTime_ValIn;
        if (ClockTime_Nanosecond_DatIn < delay_ns) begin
            stamp_ns  = ClockTime_Nanosecond_DatIn + ns_wrap;
            stamp_sec = ClockTime_Second_DatIn - 32'd1;
        end else begin
            stamp_ns  = ClockTime_Nanosecond_DatIn - delay_ns;
            stamp_sec = ClockTime_Second_DatIn;
        end
    end

    always_ff @(posedge SysClk_ClkIn or negedge SysRstN_RstIn) begin
        if (!SysRstN_RstIn) begin
            cnt                       <= '0;
            wcnt                      <= '0;
            good                      <= '0;
            PpsTime_Second_DatOut     <= '0;
            PpsTime_Nanosecond_DatOut <= '0;
            PpsTime_ValOut            <= 1'b0;
            Period_DatOut             <= '0;
            PulseWidth_DatOut         <= '0;
            MissingPps_DatOut         <= 1'b0;
            EarlyPps_DatOut           <= 1'b0;
            Locked_DatOut             <= 1'b0;
        end else begin
            PpsTime_ValOut <= stamp;
            if (stamp) begin
                PpsTime_Second_DatOut     <= stamp_sec;
                PpsTime_Nanosecond_DatOut <= stamp_ns;
            end

            // A flag event beats a coincident clear
            MissingPps_DatOut <= (MissingPps_DatOut & ~Clear_ValIn)
                                 | missing_evt;
            EarlyPps_DatOut   <= (EarlyPps_DatOut & ~Clear_ValIn)
                                 | early_evt;

            if (state == IDLE) begin
                cnt           <= '0;
                wcnt          <= '0;
                good          <= '0;
                Locked_DatOut <= 1'b0;
            end else begin
                if (rise)
                    cnt <= '0;
                else if (state == RUNNING && cnt != max_val)
                    cnt <= cnt + 32'd1;

                if (rise_run) Period_DatOut <= period_meas;

                if (fall) begin
                    PulseWidth_DatOut <= wcnt;
                    wcnt              <= '0;
                end else if (level_q && wcnt != max_val) begin
                    wcnt <= wcnt + 32'd1;
                end

                if (missing_evt || early_evt || (rise_run && !good_evt)) begin
                    good          <= '0;
                    Locked_DatOut <= 1'b0;
                end else if (good_evt) begin
                    good <= good_inc;
                    if (good_inc >= lock_lim) Locked_DatOut <= 1'b1;
                end
            end
        end
    end

endmodule
